// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch stage: PC, imem req/gnt + rvalid/rready, static prediction, IF/ID slot
// Optional backward-taken/forward-not-taken branch prediction: define IFU_BTFN_PRED_EN.
module ifu_fetch #(
    parameter int                   CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [CPU_WIDTH-1:0] NOP_INST  = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [CPU_WIDTH-1:0] redirect_pc,
    output logic                 imem_req,
    output logic [CPU_WIDTH-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [CPU_WIDTH-1:0] imem_rdata,
    output logic                 imem_rready,
    output logic [CPU_WIDTH-1:0] inst,
    output logic [CPU_WIDTH-1:0] curr_pc,
    output logic [CPU_WIDTH-1:0] next_pc,
    output logic                 control_hazard
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_KILL} state_t;

    localparam logic [CPU_WIDTH-1:0] ALIGN_MASK = ~CPU_WIDTH'(3);

    state_t                 state_q, state_d;
    logic   [CPU_WIDTH-1:0] pc_q;
    logic                   slot_valid;
    logic   [CPU_WIDTH-1:0] slot_inst, slot_pc, slot_next;
    logic                   slot_hz;

    logic                   resp_fire, fill;
    logic   [CPU_WIDTH-1:0] j_imm, pred_next;
    logic                   pred_taken;

    assign resp_fire = imem_rvalid && imem_rready;
    // A response landing in the redirect cycle belongs to the wrong path.
    assign fill      = (state_q == S_WAIT) && resp_fire && !redirect_valid;
    assign imem_addr = pc_q & ALIGN_MASK;

    assign j_imm = {{(CPU_WIDTH-20){imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                    imem_rdata[30:21], 1'b0};

`ifdef IFU_BTFN_PRED_EN
    logic [CPU_WIDTH-1:0] b_imm;
    assign b_imm = {{(CPU_WIDTH-12){imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                    imem_rdata[11:8], 1'b0};
`endif

    always_comb begin
        pred_next  = pc_q + CPU_WIDTH'(4);
        pred_taken = 1'b0;
        if (imem_rdata[6:0] == 7'b1101111) begin
            pred_next  = pc_q + j_imm;
            pred_taken = 1'b1;
        end
`ifdef IFU_BTFN_PRED_EN
        else if (imem_rdata[6:0] == 7'b1100011 && imem_rdata[31]) begin
            pred_next  = pc_q + b_imm;
            pred_taken = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (imem_gnt && !redirect_valid) state_d = S_WAIT;
            S_WAIT: begin
                if (resp_fire)           state_d = S_IDLE;
                else if (redirect_valid) state_d = S_KILL;
            end
            S_KILL: if (imem_rvalid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        imem_rready = 1'b0;
        case (state_q)
            S_IDLE: imem_req    = !redirect_valid && !rst;
            S_WAIT: imem_rready = !(slot_valid && stall) && !rst;
            S_KILL: imem_rready = !rst;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC & ALIGN_MASK;
            slot_valid <= 1'b0;
            slot_inst  <= NOP_INST;
            slot_pc    <= '0;
            slot_next  <= '0;
            slot_hz    <= 1'b0;
        end else if (redirect_valid) begin
            pc_q       <= redirect_pc & ALIGN_MASK;
            slot_valid <= 1'b0;
        end else if (fill) begin
            pc_q       <= pred_next;
            slot_valid <= 1'b1;
            slot_inst  <= imem_rdata;
            slot_pc    <= pc_q;
            slot_next  <= pred_next;
            slot_hz    <= pred_taken;
        end else if (!stall) begin
            slot_valid <= 1'b0;
        end
    end

    assign inst           = slot_valid ? slot_inst : NOP_INST;
    assign curr_pc        = slot_valid ? slot_pc   : '0;
    assign next_pc        = slot_valid ? slot_next : '0;
    assign control_hazard = slot_valid && slot_hz;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch: vector table, directed corner sequences, randomized run vs reference model
module tb_ifu_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid, imem_gnt, imem_rvalid;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, imem_rready, control_hazard;
    logic [31:0] imem_addr, inst, curr_pc, next_pc;

    int pass_cnt = 0;
    int total_cnt = 0;

    ifu_fetch dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_rready(imem_rready),
        .inst(inst), .curr_pc(curr_pc), .next_pc(next_pc), .control_hazard(control_hazard)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [31:0] exp_next;
        logic        exp_hz;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference prediction from the ISA immediate layouts: {taken, next}
    function automatic logic [32:0] predict(input logic [31:0] pc, input logic [31:0] ins);
        int signed off;
        if (ins[6:0] == 7'h6F) begin
            off = int'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
            off = (off << 11) >>> 11;
            return {1'b1, pc + 32'(off)};
        end
`ifdef IFU_BTFN_PRED_EN
        if (ins[6:0] == 7'h63 && ins[31]) begin
            off = int'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
            off = (off << 19) >>> 19;
            return {1'b1, pc + 32'(off)};
        end
`endif
        return {1'b0, pc + 32'd4};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a[4:2])
            3'd4:    return a[6] ? 32'hFF1F_F06F : 32'h0100_006F;
            3'd5:    return 32'hFE00_0CE3;
            3'd6:    return 32'h0000_0463;
            3'd7:    return 32'h0000_8067;
            default: return {a[13:2], 20'h00013};
        endcase
    endfunction

    task automatic fetch_one(input logic [31:0] data);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!imem_req) chk("req_timeout", {31'b0, imem_req}, 32'd1);
        imem_gnt = 1'b1;
        @(posedge clk); #1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        #1;
        n = 0;
        while (!imem_rready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!imem_rready) chk("rready_timeout", {31'b0, imem_rready}, 32'd1);
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        #1;
    endtask

    logic        m_out, m_killed, obs_valid, prev_hold;
    int          m_delay, consumed;
    logic [31:0] m_addr, exp_pc, fetch_exp, prev_inst, prev_pc;
    logic [32:0] p;

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        vecs[0] = '{32'h0000_0000, 32'h0000_0013, 32'h0000_0004, 1'b0};
        vecs[1] = '{32'h0000_0008, 32'h1000_006F, 32'h0000_0108, 1'b1};
`ifdef IFU_BTFN_PRED_EN
        vecs[2] = '{32'h0000_0040, 32'hFE00_0CE3, 32'h0000_0038, 1'b1};
`else
        vecs[2] = '{32'h0000_0040, 32'hFE00_0CE3, 32'h0000_0044, 1'b0};
`endif
        vecs[3] = '{32'h0000_0010, 32'h0000_8067, 32'h0000_0014, 1'b0};
        vecs[4] = '{32'h0000_0020, 32'h0000_0463, 32'h0000_0024, 1'b0};
        vecs[5] = '{32'h0000_0000, 32'hFF9F_F06F, 32'hFFFF_FFF8, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_inst", inst, NOP);
        chk("rst_curr_pc", curr_pc, 32'd0);
        chk("rst_next_pc", next_pc, 32'd0);
        chk("rst_hz", {31'b0, control_hazard}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_rready", {31'b0, imem_rready}, 32'd0);

        rst = 1'b0;
        #1;
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        fetch_one(32'h0000_0013);
        chk("f0_curr_pc", curr_pc, 32'h0);
        chk("f0_next_pc", next_pc, 32'h4);
        chk("f0_hz", {31'b0, control_hazard}, 32'd0);
        chk("f1_addr", imem_addr, 32'h4);
        fetch_one(32'h0000_0013);
        chk("f1_curr_pc", curr_pc, 32'h4);

        for (int i = 0; i < 6; i++) begin
            redirect_to(vecs[i].pc);
            fetch_one(vecs[i].rdata);
            chk($sformatf("vec%0d_inst", i), inst, vecs[i].rdata);
            chk($sformatf("vec%0d_curr_pc", i), curr_pc, vecs[i].pc);
            chk($sformatf("vec%0d_next_pc", i), next_pc, vecs[i].exp_next);
            chk($sformatf("vec%0d_hz", i), {31'b0, control_hazard}, {31'b0, vecs[i].exp_hz});
            chk($sformatf("vec%0d_next_addr", i), imem_addr, vecs[i].exp_next);
        end

        // Response arrives while stalled with a full slot
        redirect_to(32'h100);
        fetch_one(32'h0000_0013);
        stall    = 1'b1;
        imem_gnt = 1'b1;
        @(posedge clk); #1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0020_0113;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("stall_rready", {31'b0, imem_rready}, 32'd0);
            chk("stall_curr_pc", curr_pc, 32'h100);
            chk("stall_inst", inst, NOP);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        #1;
        chk("unstall_rready", {31'b0, imem_rready}, 32'd1);
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        #1;
        chk("unstall_inst", inst, 32'h0020_0113);
        chk("unstall_curr_pc", curr_pc, 32'h104);

        // Redirect while waiting for a response
        imem_gnt = 1'b1;
        @(posedge clk); #1;
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        #1;
        chk("kill_req", {31'b0, imem_req}, 32'd0);
        chk("kill_inst", inst, NOP);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1000_006F;
        #1;
        chk("kill_rready", {31'b0, imem_rready}, 32'd1);
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        #1;
        chk("kill_drop_inst", inst, NOP);
        chk("kill_drop_pc", curr_pc, 32'h0);
        chk("kill_next_req", {31'b0, imem_req}, 32'd1);
        chk("kill_next_addr", imem_addr, 32'h200);

        // Asynchronous reset while a request is outstanding
        fetch_one(32'h0000_0013);
        stall    = 1'b1;
        imem_gnt = 1'b1;
        @(posedge clk); #1;
        imem_gnt = 1'b0;
        chk("pre_rst_curr_pc", curr_pc, 32'h200);
        rst = 1'b1;
        #1;
        chk("async_rst_inst", inst, NOP);
        chk("async_rst_curr_pc", curr_pc, 32'h0);
        chk("async_rst_next_pc", next_pc, 32'h0);
        chk("async_rst_hz", {31'b0, control_hazard}, 32'd0);
        stall = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("post_rst_req", {31'b0, imem_req}, 32'd1);

        // Randomized run against the reference model
        m_out = 1'b0; m_killed = 1'b0; m_delay = 0; m_addr = '0;
        exp_pc = 32'h0; fetch_exp = 32'h0; prev_hold = 1'b0; consumed = 0;
        prev_inst = '0; prev_pc = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            stall          = ($urandom_range(0, 9) < 3);
            redirect_valid = (cyc == 0) || ($urandom_range(0, 99) < 3);
            redirect_pc    = 32'h1000 + 32'($urandom_range(0, 1023));
            imem_rvalid    = m_out && (m_delay == 0);
            imem_rdata     = imem_rvalid ? mem_word(m_addr) : $urandom;
            #1;
            imem_gnt = imem_req && !m_out && ($urandom_range(0, 9) < 6);
            @(negedge clk);

            obs_valid = !(inst == NOP && curr_pc == 0 && next_pc == 0 && !control_hazard);
            if (prev_hold) begin
                chk("hold_inst", inst, prev_inst);
                chk("hold_curr_pc", curr_pc, prev_pc);
            end
            if (m_out) begin
                chk("busy_req", {31'b0, imem_req}, 32'd0);
                if (m_killed) chk("kill_rready_rnd", {31'b0, imem_rready}, 32'd1);
                else chk("wait_rready_rnd", {31'b0, imem_rready}, {31'b0, !(obs_valid && stall)});
            end
            if (!stall && obs_valid) begin
                p = predict(exp_pc, mem_word(exp_pc));
                chk("rnd_curr_pc", curr_pc, exp_pc);
                chk("rnd_inst", inst, mem_word(exp_pc));
                chk("rnd_next_pc", next_pc, p[31:0]);
                chk("rnd_hz", {31'b0, control_hazard}, {31'b0, p[32]});
                exp_pc = p[31:0];
                consumed++;
            end
            if (imem_req && imem_gnt && !redirect_valid) begin
                chk("rnd_fetch_addr", imem_addr, fetch_exp);
                m_out    = 1'b1;
                m_addr   = imem_addr;
                m_delay  = $urandom_range(0, 3);
                m_killed = 1'b0;
            end else if (imem_rvalid && imem_rready) begin
                m_out = 1'b0;
                if (!redirect_valid && !m_killed) begin
                    p = predict(m_addr, mem_word(m_addr));
                    fetch_exp = p[31:0];
                end
            end else if (m_out && m_delay > 0) begin
                m_delay--;
            end
            if (redirect_valid) begin
                if (m_out) m_killed = 1'b1;
                fetch_exp = redirect_pc & 32'hFFFF_FFFC;
                exp_pc    = redirect_pc & 32'hFFFF_FFFC;
            end
            prev_hold = stall && !redirect_valid && obs_valid;
            prev_inst = inst;
            prev_pc   = curr_pc;
        end
        chk("rnd_progress", {31'b0, consumed > 200}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction-fetch stage. It is the producer side of the IF/ID pipeline register.
- Owns the PC and issues requests to instruction memory over a req/gnt address phase and a valid/ready response phase.
- Statically predicts the next PC.
- Drives inst, curr_pc, next_pc and control_hazard into IF/ID every cycle, re-presenting the same values while stalled.
- Takes mispredict redirects from EX.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
NOP_INST, 32'h0000_0013, instruction driven when no valid fetch (addi x0,x0,0)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
stall  input  1  hazard unit: hold current IF/ID inputs
redirect_valid  input  1  EX mispredict/jump redirect
redirect_pc  input  CPU_WIDTH  redirect target
imem_req  output  1  request address phase
imem_addr  output  CPU_WIDTH  fetch address, word aligned
imem_gnt  input  1  address accepted
imem_rvalid  input  1  response valid
imem_rdata  input  CPU_WIDTH  fetched instruction
imem_rready  output  1  response accepted
inst  output  CPU_WIDTH  to IF/ID inst
curr_pc  output  CPU_WIDTH  to IF/ID curr_pc
next_pc  output  CPU_WIDTH  predicted next PC
control_hazard  output  1  prediction was taken

Behaviour:
Reset values (async):
- pc_q=RESET_PC; state=IDLE; out slot empty.
- inst=NOP_INST; curr_pc=0; next_pc=0; control_hazard=0.
- imem_req=0; imem_rready=0.

State machine (single outstanding request):
- IDLE:
  - imem_req=1, imem_addr={pc_q[31:2],2'b00}.
  - On gnt (and no redirect) -> WAIT.
  - redirect_valid in IDLE: the request is aborted; no grant is taken.
- WAIT:
  - imem_rready = !(slot_valid && stall).
  - On rvalid&&rready: fill slot; pc_q<=predicted next; -> IDLE. The next request issues the following cycle.
- KILL:
  - Entered from WAIT on redirect.
  - imem_rready=1.
  - On rvalid, discard the data -> IDLE.

Output slot:
- Valid slot: outputs are the registered inst/curr_pc/next_pc/control_hazard.
- Empty slot: outputs are NOP_INST / 0 / 0 / 0.
- The slot is consumed at a clock edge when stall=0. Consumed and not refilled -> empty.
- stall=1: slot and outputs held bit-exact.
- Fetch-to-output latency: the response is accepted at edge N; outputs change after edge N.

Prediction (combinational on accepted imem_rdata, pc = PC of that fetch):
- opcode 1101111 (JAL): next = pc + sext(J-imm), control_hazard=1.
- opcode 1100011 (BRANCH): per the optional feature.
- All others, including JALR: next = pc+4, control_hazard=0.
- Arithmetic is 32-bit modulo; it wraps at 2^32 and no trap is raised.

Redirect:
- Highest priority; overrides stall.
- pc_q<={redirect_pc[31:2],2'b00}.
- Slot emptied at the same edge.
- WAIT -> KILL.
- A response arriving in the redirect cycle is dropped.
- A grant in the redirect cycle is ignored (state stays IDLE).
- KILL + a new redirect: stay in KILL, pc_q updated.

Simultaneous events:
- rvalid with stall=1 and slot full: rready=0; memory holds the response.
- Consume and fill in the same edge is allowed.

Asynchronous reset mid-transaction:
- Returns everything to reset values.
- Any in-flight memory response after reset is the memory's responsibility; the memory is reset by the same rst.

Optional Feature:
Macro: IFU_BTFN_PRED_EN
- Defined: BRANCH with a negative B-immediate (imem_rdata[31]=1) is predicted taken. next = pc + sext(B-imm), control_hazard=1. Forward branches: pc+4, control_hazard=0.
- Undefined: all BRANCH instructions are predicted not taken: next = pc+4, control_hazard=0.

Test Plan:
1. Reset release, memory 1-cycle gnt/rvalid, rdata=32'h00000013 at 0x0 and 0x4. Required: imem_addr 0x0 then 0x4; curr_pc=0x0, next_pc=0x4, control_hazard=0.
2. JAL at 0x8 with offset +0x100 (rdata=32'h1000006F). Required: next_pc=0x108, control_hazard=1, next imem_addr=0x108.
3. Response arrives while stall=1 with slot full. Required: imem_rready=0, outputs unchanged for the 3 stall cycles. Stall drops: next instruction appears after one edge.
4. Redirect to 0x203 in WAIT. Required: the response is discarded (no slot fill, inst=NOP), next imem_addr=0x200.
5. BEQ at 0x40 with offset -8 (rdata=32'hFE000CE3). With IFU_BTFN_PRED_EN: next_pc=0x38, control_hazard=1. Without: next_pc=0x44, control_hazard=0.
6. rst asserted mid-WAIT. Required: outputs immediately NOP/0/0/0; imem_addr=RESET_PC after release.
